regfile_read_arbiter: RTL
=========================

// Module: regfile_read_arbiter
// PURPOSE
//   Shares one register-file read port (5-bit select into the 32x64 read mux, 64-bit data back) among NUM_REQ requesters.
//   Round-robin arbitration, valid/ready request handshake, one registered response slot with backpressure.
//   Write-to-read bypass so a same-cycle write is seen. Sits between the decode/issue requesters and the regfile read mux.
// PARAMETERS
//   NUM_REQ   4   number of requesters (>=1); IDW = $clog2(NUM_REQ), min 1
// PORTS
//   clk        in   1            clock, rising edge
//   reset_n    in   1            asynchronous, active-low reset
//   req_valid  in   NUM_REQ      per-requester read request
//   req_addr   in   NUM_REQ x 5  per-requester register number; held stable while valid && !ready
//   req_ready  out  NUM_REQ      one-hot (or zero) accept strobe
//   rd_sel     out  5            select to regfile read mux
//   rd_data    in   64           read mux output for rd_sel, same cycle
//   wr_en      in   1            regfile write enable this cycle
//   wr_addr    in   5            regfile write register
//   wr_data    in   64           regfile write data
//   rsp_valid  out  1            response slot holds data
//   rsp_id     out  IDW          requester index owning the response
//   rsp_data   out  64           read value
//   rsp_ready  in   1            consumer takes response this cycle
// BEHAVIOUR
//   - Reset (async assert, sync release): rsp_valid=0, rsp_id=0, rsp_data=0, rr_ptr=0; all req_ready=0.
//   - slot_free = !rsp_valid || rsp_ready (combinational).
//   - Arbitration (comb): winner = first k with req_valid[k], scanning rr_ptr, rr_ptr+1, ... wrapping mod NUM_REQ.
//   - req_ready[winner] = slot_free; all others 0. No req_valid -> req_ready all 0.
//   - rd_sel = req_addr[winner] when a winner exists, else 5'd0.
//   - Accept = req_valid[k] && req_ready[k]. On accept, next edge:
//       rsp_valid<=1, rsp_id<=k, rr_ptr<=(k+1) mod NUM_REQ,
//       rsp_data<= (wr_en && wr_addr==rd_sel && rd_sel!=ZERO_REG) ? wr_data : rd_data.
//   - No bypass for ZERO_REG (31): always rd_data (mux returns 0 for X31).
//   - rsp_valid && rsp_ready && no accept -> rsp_valid<=0; rsp_id/rsp_data keep old values.
//   - rsp_valid && !rsp_ready -> rsp_id/rsp_data frozen, no accept (all req_ready=0).
//   - Drain and accept in the same cycle: slot reloads, rsp_valid stays 1 (back-to-back, 1 rsp/cycle).
//   - Latency: accept in cycle N -> rsp_valid with data in cycle N+1.
//   - rr_ptr advances only on accept; a stalled slot does not rotate priority.
//   - Reset asserted mid-operation: pending response discarded, no replay.
//   - NUM_REQ=1: rr_ptr constant 0, rsp_id constant 0.
//   - Slot state: EMPTY (rsp_valid=0) -> FULL on accept; FULL -> EMPTY on rsp_ready without accept; FULL -> FULL otherwise.
// STRUCTURE
//   - Package regfile_pkg: REG_W=64, ADDR_W=5, NUM_REGS=32, ZERO_REG=5'd31, typedef logic [ADDR_W-1:0] reg_addr_t, typedef logic [REG_W-1:0] reg_data_t.
//   - Sub-module rr_arbiter #(N): req vector + rr_ptr in -> one-hot grant + index + any_grant out, purely combinational.
//   - Top holds rr_ptr, response slot registers, bypass compare, rd_sel mux.
// TESTING
//   1. Reset: reset_n=0 with req_valid=4'b1111 -> rsp_valid=0, req_ready=0000; release, no req -> rd_sel=0.
//   2. Single: req0 addr=3, rd_data=64'd12328, rsp_ready=1 -> req_ready=0001, next cycle rsp_valid=1, rsp_id=0, rsp_data=12328.
//   3. Round-robin: all 4 valid every cycle, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, rsp_valid held 1.
//   4. Backpressure: rsp full, rsp_ready=0 for 3 cycles with req2 valid -> req_ready=0, rsp_data frozen;
//      rsp_ready=1 -> req2 accepted that same cycle.
//   5. Bypass: req1 addr=7, wr_en=1 wr_addr=7 wr_data=64'hDEAD -> rsp_data=64'hDEAD;
//      same with addr=31 wr_addr=31 -> rsp_data=rd_data(0).
//   6. Mid-op reset: rsp_valid=1 pending, pulse reset_n=0 -> rsp_valid=0, rr_ptr=0 (next grant to req0 when all valid).

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths and types for the register-file read path.
package regfile_pkg;

  localparam int unsigned REG_W    = 64;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_W-1:0]  reg_data_t;

  // Hard-wired zero register: the read mux returns 0 for it, so never bypass.
  localparam reg_addr_t ZERO_REG = 5'd31;

  // Response slot occupancy.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after i_ptr wins.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  // Scan i_ptr, i_ptr+1, ... wrapping; the first asserted request takes the grant.
  always_comb begin
    int unsigned k;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      k = (32'(i_ptr) + i) % N;
      if (!o_any && i_req[k]) begin
        o_any    = 1'b1;
        o_idx    = IW'(k);
        o_gnt[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares one regfile read port among NUM_REQ requesters with a single
// registered response slot and write-to-read bypass.
module regfile_read_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [ADDR_W-1:0]              rd_sel,
  input  logic [REG_W-1:0]               rd_data,
  input  logic                           wr_en,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic [REG_W-1:0]               wr_data,
  output logic                           rsp_valid,
  output logic [IDW-1:0]                 rsp_id,
  output logic [REG_W-1:0]               rsp_data,
  input  logic                           rsp_ready
);

  slot_state_t      r_state;
  slot_state_t      w_state_nxt;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_rsp_id;
  reg_data_t        r_rsp_data;

  logic [NUM_REQ-1:0] w_gnt;
  logic [IDW-1:0]     w_idx;
  logic               w_any;
  logic               w_slot_free;
  logic               w_accept;
  logic               w_bypass;
  logic [IDW-1:0]     w_ptr_nxt;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDW)
  ) u_arb (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // Grant, read select, bypass and next-pointer decode; reset_n gates the
  // accept strobe so nothing is handed out while reset is held.
  always_comb begin
    w_slot_free = reset_n && ((r_state == SLOT_EMPTY) || rsp_ready);
    w_accept    = w_any && w_slot_free;
    req_ready   = w_slot_free ? w_gnt : '0;
    rd_sel      = w_any ? req_addr[w_idx] : '0;
    w_bypass    = wr_en && (wr_addr == rd_sel) && (rd_sel != ZERO_REG);
    w_ptr_nxt   = (w_idx == IDW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
  end

  // Slot next-state: accept fills, drain without accept empties.
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = SLOT_FULL;
    end else if (r_state == SLOT_FULL && rsp_ready) begin
      w_state_nxt = SLOT_EMPTY;
    end
  end

  // Slot state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= SLOT_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Response payload and priority pointer update only on accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr   <= '0;
      r_rsp_id   <= '0;
      r_rsp_data <= '0;
    end else if (w_accept) begin
      r_rr_ptr   <= w_ptr_nxt;
      r_rsp_id   <= w_idx;
      r_rsp_data <= w_bypass ? wr_data : rd_data;
    end
  end

  assign rsp_valid = (r_state == SLOT_FULL);
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;

endmodule
